// File: rtl/seq_ctrl.sv
// seq_ctrl: instruction sequencer for the 4-bit core.
// Walks FETCH -> DECODE -> EXEC -> WB per instruction, drives PC strobes,
// latches the fetched word into ir and halts on HLT, end of program or fetch timeout.
// Optional feature macro: SINGLE_STEP_EN (adds step input and PAUSE state after WB).
module seq_ctrl #(
    parameter int ADDR_W      = 5,
    parameter int INSTR_W     = 8,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  pc_val,
    input  logic               pc_max,
    output logic               pc_inc,
    output logic               pc_load,
    output logic [ADDR_W-1:0]  pc_load_val,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] ir,
    input  logic               flag_z,
    output logic               alu_en,
    output logic               reg_we,
    output logic               busy,
    output logic               halted,
    output logic               err
`ifdef SINGLE_STEP_EN
    ,
    input  logic               step
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
`ifdef SINGLE_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    // Last counter value before the timeout fires: TIMEOUT_CYC fetch cycles in total.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q;
    logic [7:0]         cnt_q;
    logic               err_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               jmp_q;     // EXEC issued a pc_load for the current instruction

    logic [3:0] op;
    logic       is_alu;
    logic       take;

    assign op     = ir_q[7:4];
    assign is_alu = (op != 4'h0) && (op <= 4'hC);
    assign take   = (op == 4'hE) || ((op == 4'hD) && flag_z);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_d     = state_q;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = '0;
        mem_req     = 1'b0;
        alu_en      = 1'b0;
        reg_we      = 1'b0;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack)              state_d = S_DECODE;
                else if (cnt_q == TO_LAST) state_d = S_HALT;
            end
            S_DECODE: state_d = (op == 4'hF) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (take) begin
                    pc_load     = 1'b1;
                    pc_load_val = ADDR_W'(ir_q[3:0]);
                end else begin
                    pc_inc = 1'b1;
                end
                alu_en  = is_alu;
                state_d = S_WB;
            end
            S_WB: begin
                reg_we = is_alu;
                if (pc_max && !jmp_q) state_d = S_HALT;
`ifdef SINGLE_STEP_EN
                else                  state_d = S_PAUSE;
`else
                else                  state_d = S_FETCH;
`endif
            end
`ifdef SINGLE_STEP_EN
            S_PAUSE:  if (step) state_d = S_FETCH;
`endif
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath: address capture, instruction latch, timeout counter, sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q   <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            addr_q <= '0;
            jmp_q  <= 1'b0;
        end else begin
            if (state_d == S_FETCH && state_q != S_FETCH) addr_q <= pc_val;
            if (state_q == S_FETCH) begin
                if (mem_ack) begin
                    ir_q  <= mem_rdata;
                    cnt_q <= '0;
                end else if (cnt_q == TO_LAST) begin
                    err_q <= 1'b1;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
            if (state_q == S_EXEC) jmp_q <= pc_load;
        end
    end

    assign mem_addr = addr_q;
    assign ir       = ir_q;
    assign err      = err_q;
    assign halted   = (state_q == S_HALT);
    assign busy     = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule
